// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the pipeline-to-memory bus arbiter.
package cpu_mem_pkg;

    localparam int unsigned ADDR_WIDTH_DFLT = 32;
    localparam int unsigned DATA_WIDTH_DFLT = 32;
    localparam int unsigned BE_WIDTH_DFLT   = DATA_WIDTH_DFLT / 8;
    localparam int unsigned STARVE_W        = 4;

    // All byte lanes enabled; truncated to the bus byte-enable width at the use site.
    localparam logic [63:0] FETCH_BE_ALL = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUS_IF = 2'd1,
        ST_BUS_DM = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        RSP_IF = 1'b0,
        RSP_DM = 1'b1
    } resp_sel_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Bus-cycle watchdog: counts enabled cycles and flags the final cycle before TIMEOUT.
module mem_arb_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // TIMEOUT of zero disables expiry entirely.
    assign expire_c = (TIMEOUT != 0) && en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and load/store,
// holding the bus stable until acknowledged and returning registered responses.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DFLT,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DFLT,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    output logic                    if_ack_o,
    input  logic                    dm_req_i,
    input  logic                    dm_we_i,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dm_be_i,
    output logic [DATA_WIDTH-1:0]   dm_rdata_o,
    output logic                    dm_ack_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ack_i,
    output logic                    stall_o,
    output logic                    err_o
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    arb_state_e            state_q, state_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  mem_req_d, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic [BE_W-1:0]       mem_be_d;
    logic                  if_ack_d, dm_ack_d, err_d;
    logic [DATA_WIDTH-1:0] if_rdata_d, dm_rdata_d, rsp_data;
    resp_sel_e             rsp_sel;
    logic                  on_bus, expire_c;

    assign on_bus = (state_q == ST_BUS_IF) || (state_q == ST_BUS_DM);

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (on_bus && !mem_ack_i),
        .clr      (state_q == ST_RESP),
        .expire_c (expire_c)
    );

    // Next-state, arbitration and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_o;
        mem_we_d    = mem_we_o;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        mem_be_d    = mem_be_o;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_o;
        dm_rdata_d  = dm_rdata_o;
        rsp_data    = '0;
        rsp_sel     = (state_q == ST_BUS_IF) ? RSP_IF : RSP_DM;

        case (state_q)
            ST_IDLE: begin
                if (dm_req_i && (!if_req_i || (starve_q < STARVE_W'(STARVE_LIMIT)))) begin
                    state_d     = ST_BUS_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    mem_be_d    = dm_be_i;
                    // Grant only reaches here below the limit, so +1 saturates naturally.
                    starve_d    = if_req_i ? (starve_q + STARVE_W'(1)) : '0;
                end else if (if_req_i) begin
                    state_d     = ST_BUS_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    mem_be_d    = BE_W'(FETCH_BE_ALL);
                    starve_d    = '0;
                end else begin
                    starve_d    = '0;
                end
            end
            ST_BUS_IF, ST_BUS_DM: begin
                if (mem_ack_i || expire_c) begin
                    rsp_data  = (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
                    err_d     = !mem_ack_i;
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                    if (rsp_sel == RSP_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = rsp_data;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = rsp_data;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            if_ack_o    <= 1'b0;
            dm_ack_o    <= 1'b0;
            err_o       <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_o   <= mem_req_d;
            mem_we_o    <= mem_we_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            mem_be_o    <= mem_be_d;
            if_ack_o    <= if_ack_d;
            dm_ack_o    <= dm_ack_d;
            err_o       <= err_d;
            if_rdata_o  <= if_rdata_d;
            dm_rdata_o  <= dm_rdata_d;
        end
    end

    // Combinational so the hazard unit sees a new request in the same cycle.
    assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-ported unified memory bus between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sits between the pipeline stages and the memory.
- Grants one requester at a time and holds the bus stable until the memory acknowledges.
- Returns registered read data and exports a stall request to the hazard/control logic.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, bus data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (1..15).
- TIMEOUT, 64, cycles to wait for mem_ack_i before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch request, level, held until if_ack_o.
- if_addr_i  in  ADDR_WIDTH  fetch address.
- if_rdata_o  out  DATA_WIDTH  fetched instruction, valid with if_ack_o.
- if_ack_o  out  1  one-cycle fetch completion.
- dm_req_i  in  1  data request, level, held until dm_ack_o.
- dm_we_i  in  1  1 = store.
- dm_addr_i  in  ADDR_WIDTH  data address.
- dm_wdata_i  in  DATA_WIDTH  store data.
- dm_be_i  in  DATA_WIDTH/8  byte enables.
- dm_rdata_o  out  DATA_WIDTH  load data, valid with dm_ack_o.
- dm_ack_o  out  1  one-cycle data completion.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write enable.
- mem_addr_o  out  ADDR_WIDTH  bus address.
- mem_wdata_o  out  DATA_WIDTH  bus write data.
- mem_be_o  out  DATA_WIDTH/8  bus byte enables.
- mem_rdata_i  in  DATA_WIDTH  bus read data, valid with mem_ack_i.
- mem_ack_i  in  1  bus completion.
- stall_o  out  1  pipeline stall request.
- err_o  out  1  one-cycle pulse when a transaction times out.

Behaviour:
- Reset values:
  - State IDLE.
  - mem_req_o, mem_we_o, if_ack_o, dm_ack_o, err_o = 0.
  - All address, data and byte-enable outputs = 0.
  - Starvation counter and timeout counter = 0.
  - A reset mid-transaction abandons the bus cycle: mem_req_o drops the next edge and no ack is issued.
- States: IDLE, BUS_IF, BUS_DM, RESP.
- IDLE, arbitration:
  - If dm_req_i and (!if_req_i or starve_cnt < STARVE_LIMIT): go to BUS_DM.
  - Else if if_req_i: go to BUS_IF.
  - Default priority is data (the older instruction).
  - The chosen request's payload (we, addr, wdata, be) is registered onto the mem_* outputs. For BUS_IF: we = 0, be = all ones, wdata = 0.
- BUS_IF / BUS_DM:
  - mem_req_o = 1; all mem_* outputs stay constant.
  - On mem_ack_i: capture mem_rdata_i (0 for stores) into the response register, drop mem_req_o, go to RESP.
  - timeout_cnt increments each cycle without ack. When TIMEOUT != 0 and timeout_cnt == TIMEOUT-1 without ack: response data = 0, err_o = 1 in RESP, go to RESP.
- RESP:
  - Exactly one of if_ack_o / dm_ack_o = 1, with its rdata register. The other rdata holds its previous value.
  - Go to IDLE. timeout_cnt is cleared.
  - Requesters drop or replace their request in the cycle after ack; IDLE samples it fresh.
- Latency:
  - A request seen in IDLE at cycle N drives mem_req_o at N+1.
  - With mem_ack_i at N+1, the ack appears at N+2; the next arbitration happens at N+3.
  - Minimum occupancy is 3 cycles per transaction.
- Starvation counter:
  - Increments on each BUS_DM grant made while if_req_i = 1, saturating at STARVE_LIMIT.
  - Clears on any BUS_IF grant, or in IDLE when if_req_i = 0.
- mem_ack_i outside BUS_* states is ignored.
- stall_o is combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).

Decomposition:
- Package cpu_mem_pkg:
  - State enum encoding (2 bits).
  - Width localparams derived from ADDR_WIDTH and DATA_WIDTH.
  - Constant for the all-ones fetch byte enable.
  - Response-select encoding (IF/DM).
- One natural sub-module, mem_arb_timer: the timeout counter with its enable, clear and expire outputs. It is reused by a later bus bridge.
- Arbitration and the FSM stay in the top block.

Test Plan:
- Single fetch: if_req_i = 1, if_addr_i = 0x100; mem_ack_i one cycle after mem_req_o with rdata 0x00500093.
  - Required: mem_addr_o = 0x100, mem_we_o = 0; if_ack_o = 1 for exactly one cycle with if_rdata_o = 0x00500093 at N+2; stall_o = 1 until the ack cycle.
- Collision: if_req_i and dm_req_i (load, addr 0x2000) both asserted in the same IDLE cycle.
  - Required: BUS_DM first, dm_ack_o returns the memory word; then BUS_IF; never both acks in one cycle.
- Store: dm_we_i = 1, addr 0x2004, wdata 0xDEADBEEF, be = 4'b0011; mem_ack_i after 3 wait cycles.
  - Required: mem_* outputs stable for all 4 cycles; dm_ack_o pulses with dm_rdata_o = 0.
- Starvation: STARVE_LIMIT = 4; dm_req_i continuously re-asserted and if_req_i held.
  - Required: exactly 4 data transactions, then one fetch, then data resumes.
- Timeout: TIMEOUT = 8; mem_ack_i never asserted.
  - Required: after 8 BUS cycles, err_o and the granted ack pulse together with rdata = 0; state returns to IDLE.
- Reset mid-op: rst = 1 during BUS_DM.
  - Required: next edge mem_req_o = 0, no dm_ack_o, all outputs at reset values; a new request after reset is served normally.
